// File: rtl/paula_audio_sddecode_pkg.sv
// Shared constants for the Paula sigma-delta audio decoder.
// Holds the default PCM width, decimation ratio and CIC order, the derived
// CIC register width and the PCM saturation limits.
package paula_audio_sddecode_pkg;

    localparam int DW       = 15;               // PCM output width
    localparam int DEC_LOG2 = 4;                // log2 of decimation ratio (R = 16)
    localparam int ORDER    = 3;                // CIC order N

    // Register growth of an N-stage CIC with M=1 is N*log2(R) over a 2-bit input.
    localparam int CIC_W    = 2 + ORDER * DEC_LOG2;   // 14

    localparam int SAT_MAX  = 16383;
    localparam int SAT_MIN  = -16384;

    function automatic int cic_width(input int order, input int dec_log2);
        return 2 + order * dec_log2;
    endfunction

endpackage

// File: rtl/paula_audio_cic_decim.sv
// Single-channel CIC decimator (M=1) for a 1-bit sigma-delta stream.
//   clk       : bus clock
//   reset_n   : asynchronous active-low reset
//   enable    : low clears all state synchronously
//   clk7_en   : bitstream sample enable, clocks the integrators
//   frame_end : phase counter is at its last value; with clk7_en, runs the combs
//   load      : one-cycle strobe, loads the saturated comb result into pcm
//   din       : bitstream, 1 = +1, 0 = -1
//   pcm       : saturated PCM sample, two's complement
module paula_audio_cic_decim
    import paula_audio_sddecode_pkg::*;
#(
    parameter int DW       = paula_audio_sddecode_pkg::DW,
    parameter int DEC_LOG2 = paula_audio_sddecode_pkg::DEC_LOG2,
    parameter int ORDER    = paula_audio_sddecode_pkg::ORDER
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic                 clk7_en,
    input  logic                 frame_end,
    input  logic                 load,
    input  logic                 din,
    output logic signed [DW-1:0] pcm
);

    localparam int CW = cic_width(ORDER, DEC_LOG2);

    // Limits expressed at the width of the shifted comb result (CW+2).
    localparam logic signed [CW+1:0] SAT_HI = $signed((CW+2)'(2**(DW-1) - 1));
    localparam logic signed [CW+1:0] SAT_LO = ~SAT_HI;

    logic signed [1:0]    x_bit;
    logic signed [CW-1:0] x_p0;
    logic signed [CW-1:0] integ     [ORDER];
    logic signed [CW-1:0] integ_nxt [ORDER];
    logic signed [CW-1:0] dly       [ORDER];
    logic signed [CW-1:0] comb_in   [ORDER];
    logic signed [CW-1:0] comb_out  [ORDER];
    logic signed [CW-1:0] comb_p1;

    // Scale the comb result by 4 into the PCM range and clamp.
    function automatic logic signed [DW-1:0] sat_pcm(input logic signed [CW-1:0] v);
        logic signed [CW+1:0] s;
        s = {v, 2'b00};
        if (s > SAT_HI) begin
            return SAT_HI[DW-1:0];
        end else if (s < SAT_LO) begin
            return SAT_LO[DW-1:0];
        end else begin
            return s[DW-1:0];
        end
    endfunction

    // Integrators are a registered cascade; modulo wrap is intentional, the
    // combs undo it exactly as long as the true output fits in CW bits.
    always_comb begin
        x_bit        = din ? 2'sb01 : 2'sb11;
        x_p0         = {{(CW-2){x_bit[1]}}, x_bit};
        integ_nxt[0] = integ[0] + x_p0;
        for (int k = 1; k < ORDER; k++) begin
            integ_nxt[k] = integ[k] + integ[k-1];
        end
        // Combs see the post-update value of the last integrator.
        comb_in[0]  = integ_nxt[ORDER-1];
        comb_out[0] = comb_in[0] - dly[0];
        for (int k = 1; k < ORDER; k++) begin
            comb_in[k]  = comb_out[k-1];
            comb_out[k] = comb_in[k] - dly[k];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < ORDER; k++) begin
                integ[k] <= '0;
                dly[k]   <= '0;
            end
            comb_p1 <= '0;
            pcm     <= '0;
        end else if (!enable) begin
            for (int k = 0; k < ORDER; k++) begin
                integ[k] <= '0;
                dly[k]   <= '0;
            end
            comb_p1 <= '0;
            pcm     <= '0;
        end else begin
            // p0 -> p1: integrate every sample, comb once per frame
            if (clk7_en) begin
                for (int k = 0; k < ORDER; k++) begin
                    integ[k] <= integ_nxt[k];
                end
                if (frame_end) begin
                    for (int k = 0; k < ORDER; k++) begin
                        dly[k] <= comb_in[k];
                    end
                    comb_p1 <= comb_out[ORDER-1];
                end
            end
            // p1 -> output: saturate and present, independent of clk7_en
            if (load) begin
                pcm <= sat_pcm(comb_p1);
            end
        end
    end

endmodule

// File: rtl/paula_audio_sddecode.sv
// Stereo sigma-delta to PCM decoder for Paula audio.
// Two CIC decimators share one phase counter and one output strobe.
//   clk          : bus clock
//   reset_n      : asynchronous active-low reset
//   clk7_en      : bitstream sample enable
//   enable       : decoder run, low clears synchronously
//   left, right  : sigma-delta bitstreams, 1 = +1, 0 = -1
//   ldata, rdata : PCM samples, two's complement, held between strobes
//   sample_valid : one-clk strobe marking new ldata/rdata
module paula_audio_sddecode
    import paula_audio_sddecode_pkg::*;
#(
    parameter int DW       = paula_audio_sddecode_pkg::DW,
    parameter int DEC_LOG2 = paula_audio_sddecode_pkg::DEC_LOG2,
    parameter int ORDER    = paula_audio_sddecode_pkg::ORDER
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clk7_en,
    input  logic          enable,
    input  logic          left,
    input  logic          right,
    output logic [DW-1:0] ldata,
    output logic [DW-1:0] rdata,
    output logic          sample_valid
);

    logic [DEC_LOG2-1:0]  phase;
    logic                 frame_end;
    logic                 vld_p0;
    logic                 vld_p1;
    logic signed [DW-1:0] lpcm;
    logic signed [DW-1:0] rpcm;

    assign frame_end = &phase;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase  <= '0;
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
        end else if (!enable) begin
            // Clearing also drops a strobe that was one cycle from issue.
            phase  <= '0;
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            if (clk7_en) begin
                phase <= phase + DEC_LOG2'(1);
            end
            // p0: comb update happened this edge; p1: output loaded
            vld_p0 <= clk7_en & frame_end;
            vld_p1 <= vld_p0;
        end
    end

    paula_audio_cic_decim #(
        .DW       (DW),
        .DEC_LOG2 (DEC_LOG2),
        .ORDER    (ORDER)
    ) u_left (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .clk7_en   (clk7_en),
        .frame_end (frame_end),
        .load      (vld_p0),
        .din       (left),
        .pcm       (lpcm)
    );

    paula_audio_cic_decim #(
        .DW       (DW),
        .DEC_LOG2 (DEC_LOG2),
        .ORDER    (ORDER)
    ) u_right (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .clk7_en   (clk7_en),
        .frame_end (frame_end),
        .load      (vld_p0),
        .din       (right),
        .pcm       (rpcm)
    );

    assign ldata        = lpcm;
    assign rdata        = rpcm;
    assign sample_valid = vld_p1;

endmodule

// File: tb/tb_paula_audio_sddecode.sv
module tb_paula_audio_sddecode;

    logic        clk;
    logic        reset_n;
    logic        clk7_en;
    logic        enable;
    logic        left;
    logic        right;
    logic [14:0] ldata;
    logic [14:0] rdata;
    logic        sample_valid;

    int n_pass;
    int n_total;
    int cyc;
    int samp;
    logic prev_sv;
    int          str_cyc[$];
    logic [14:0] str_l[$];
    logic [14:0] str_r[$];

    // current bitstream patterns: bit for sample s is pat[s % len]
    logic [3:0] lp;
    int         ll;
    logic [3:0] rp;
    int         rl;

    typedef struct {
        string      name;
        logic [3:0] lp;
        int         ll;
        logic [3:0] rp;
        int         rl;
        int         div;
        int         nstr;
        logic [14:0] el;
        logic [14:0] er;
        bit          early;
        logic [14:0] e1l;
        logic [14:0] e1r;
        logic [14:0] e2l;
        logic [14:0] e2r;
    } vec_t;

    localparam int NV = 6;
    vec_t vecs [NV];

    paula_audio_sddecode dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .clk7_en      (clk7_en),
        .enable       (enable),
        .left         (left),
        .right        (right),
        .ldata        (ldata),
        .rdata        (rdata),
        .sample_valid (sample_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic bitat(input logic [3:0] p, input int len, input int s);
        logic [1:0] ix;
        ix = 2'(s % len);
        return p[ix];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (sample_valid) begin
            chk("sv_width", 32'(prev_sv), 32'd0);
            str_cyc.push_back(cyc);
            str_l.push_back(ldata);
            str_r.push_back(rdata);
        end
        prev_sv = sample_valid;
    endtask

    task automatic idle(input int n);
        clk7_en = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic run_samples(input int div, input int nsamp);
        for (int i = 0; i < nsamp * div; i++) begin
            if (i % div == 0) begin
                clk7_en = 1'b1;
                left    = bitat(lp, ll, samp);
                right   = bitat(rp, rl, samp);
                samp++;
            end else begin
                clk7_en = 1'b0;
            end
            tick();
        end
        clk7_en = 1'b0;
    endtask

    task automatic restart_counts();
        cyc  = 0;
        samp = 0;
        str_cyc.delete();
        str_l.delete();
        str_r.delete();
    endtask

    task automatic do_clear(input string name);
        enable  = 1'b0;
        clk7_en = 1'b0;
        tick();
        tick();
        chk({name, "_clr_l"},  32'(ldata), 32'd0);
        chk({name, "_clr_r"},  32'(rdata), 32'd0);
        chk({name, "_clr_sv"}, 32'(sample_valid), 32'd0);
        enable = 1'b1;
        restart_counts();
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        cyc     = 0;
        samp    = 0;
        prev_sv = 1'b0;
        reset_n = 1'b0;
        clk7_en = 1'b0;
        enable  = 1'b0;
        left    = 1'b0;
        right   = 1'b0;
        lp = 4'b0001; ll = 1; rp = 4'b0000; rl = 1;

        // constant +1 frames give 560, 3280, then 4096 (x4 into PCM)
        vecs[0] = '{"const_l1_r0", 4'b0001, 1, 4'b0000, 1, 1, 5, 15'h3FFF, 15'h4000,
                    1'b1, 15'h08C0, 15'h7740, 15'h3340, 15'h4CC0};
        vecs[1] = '{"const_l0_r1", 4'b0000, 1, 4'b0001, 1, 1, 5, 15'h4000, 15'h3FFF,
                    1'b1, 15'h7740, 15'h08C0, 15'h4CC0, 15'h3340};
        vecs[2] = '{"alt_10", 4'b0001, 2, 4'b0001, 2, 1, 5, 15'h0000, 15'h0000,
                    1'b0, 15'h0, 15'h0, 15'h0, 15'h0};
        vecs[3] = '{"p1110_p0001", 4'b0111, 4, 4'b1000, 4, 1, 5, 15'h2000, 15'h6000,
                    1'b0, 15'h0, 15'h0, 15'h0, 15'h0};
        vecs[4] = '{"p1110_both", 4'b0111, 4, 4'b0111, 4, 1, 5, 15'h2000, 15'h2000,
                    1'b0, 15'h0, 15'h0, 15'h0, 15'h0};
        vecs[5] = '{"ce_div4", 4'b0001, 1, 4'b0000, 1, 4, 4, 15'h3FFF, 15'h4000,
                    1'b1, 15'h08C0, 15'h7740, 15'h3340, 15'h4CC0};

        // reset state
        tick();
        tick();
        chk("rst_l",  32'(ldata), 32'd0);
        chk("rst_r",  32'(rdata), 32'd0);
        chk("rst_sv", 32'(sample_valid), 32'd0);
        reset_n = 1'b1;
        tick();

        // table-driven vectors
        for (int vi = 0; vi < NV; vi++) begin
            vec_t v;
            v = vecs[vi];
            do_clear(v.name);
            lp = v.lp; ll = v.ll; rp = v.rp; rl = v.rl;
            run_samples(v.div, 16 * v.nstr);
            idle(2);
            chk({v.name, "_count"}, 32'(str_l.size()), 32'(v.nstr));
            for (int k = 0; k < str_l.size(); k++) begin
                if (k == 0) begin
                    chk($sformatf("%s_first_cyc", v.name), 32'(str_cyc[0]), 32'(15 * v.div + 2));
                end else begin
                    chk($sformatf("%s_period[%0d]", v.name, k),
                        32'(str_cyc[k] - str_cyc[k-1]), 32'(16 * v.div));
                end
                if (k >= 2) begin
                    chk($sformatf("%s_l[%0d]", v.name, k), 32'(str_l[k]), 32'(v.el));
                    chk($sformatf("%s_r[%0d]", v.name, k), 32'(str_r[k]), 32'(v.er));
                end else if (v.early) begin
                    chk($sformatf("%s_l[%0d]", v.name, k), 32'(str_l[k]), 32'(k == 0 ? v.e1l : v.e2l));
                    chk($sformatf("%s_r[%0d]", v.name, k), 32'(str_r[k]), 32'(k == 0 ? v.e1r : v.e2r));
                end
            end
        end

        // hold between strobes, and no progress while clk7_en is low
        do_clear("hold");
        lp = 4'b0001; ll = 1; rp = 4'b0000; rl = 1;
        run_samples(1, 48);
        idle(2);
        chk("hold_count", 32'(str_l.size()), 32'd3);
        for (int i = 0; i < 40; i++) begin
            left  = 1'($urandom);
            right = 1'($urandom);
            tick();
            chk("hold_l",  32'(ldata), 32'h3FFF);
            chk("hold_r",  32'(rdata), 32'h4000);
            chk("hold_sv", 32'(sample_valid), 32'd0);
        end
        run_samples(1, 16);
        idle(2);
        chk("hold_resume_count", 32'(str_l.size()), 32'd4);
        chk("hold_resume_l", 32'(ldata), 32'h3FFF);

        // enable dropping on the cycle a strobe is due: clear wins
        do_clear("clrwin");
        lp = 4'b0001; ll = 1; rp = 4'b0000; rl = 1;
        run_samples(1, 16);
        enable = 1'b0;
        tick();
        chk("clrwin_sv", 32'(sample_valid), 32'd0);
        chk("clrwin_l",  32'(ldata), 32'd0);
        tick();
        chk("clrwin_nostrobe", 32'(str_l.size()), 32'd0);
        enable = 1'b1;
        restart_counts();
        run_samples(1, 16);
        idle(2);
        chk("clrwin_after_count", 32'(str_l.size()), 32'd1);
        if (str_l.size() > 0) begin
            chk("clrwin_after_cyc", 32'(str_cyc[0]), 32'd17);
            chk("clrwin_after_l",   32'(str_l[0]), 32'h08C0);
        end

        // asynchronous reset at phase 7
        do_clear("midrst");
        lp = 4'b0001; ll = 1; rp = 4'b0000; rl = 1;
        run_samples(1, 55);
        chk("midrst_pre_count", 32'(str_l.size()), 32'd3);
        chk("midrst_pre_l", 32'(ldata), 32'h3FFF);
        reset_n = 1'b0;
        #1;
        chk("midrst_async_l",  32'(ldata), 32'd0);
        chk("midrst_async_r",  32'(rdata), 32'd0);
        chk("midrst_async_sv", 32'(sample_valid), 32'd0);
        clk7_en = 1'b1;
        tick();
        tick();
        clk7_en = 1'b0;
        reset_n = 1'b1;
        chk("midrst_nostrobe", 32'(str_l.size()), 32'd3);
        restart_counts();
        run_samples(1, 20);
        idle(2);
        chk("midrst_after_count", 32'(str_l.size()), 32'd1);
        if (str_l.size() > 0) begin
            chk("midrst_after_cyc", 32'(str_cyc[0]), 32'd17);
            chk("midrst_after_l",   32'(str_l[0]), 32'h08C0);
            chk("midrst_after_r",   32'(str_r[0]), 32'h7740);
        end

        // long run with integrator wrap, then the polarity flips on a frame edge
        do_clear("wrap");
        lp = 4'b0001; ll = 1; rp = 4'b0000; rl = 1;
        run_samples(1, 1008);
        lp = 4'b0000; rp = 4'b0001;
        run_samples(1, 80);
        idle(2);
        chk("wrap_count", 32'(str_l.size()), 32'd68);
        if (str_l.size() == 68) begin
            for (int k = 2; k < 63; k++) begin
                chk($sformatf("wrap_pre_l[%0d]", k), 32'(str_l[k]), 32'h3FFF);
                chk($sformatf("wrap_pre_r[%0d]", k), 32'(str_r[k]), 32'h4000);
            end
            for (int k = 65; k < 68; k++) begin
                chk($sformatf("wrap_post_l[%0d]", k), 32'(str_l[k]), 32'h4000);
                chk($sformatf("wrap_post_r[%0d]", k), 32'(str_r[k]), 32'h3FFF);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/paula_audio_sddecode.md
PAULA_AUDIO_SDDECODE -- requirements
Module: paula_audio_sddecode

Interface
REQ-001 The block SHALL have these parameters: DW, default 15, PCM output width; DEC_LOG2, default 4, log2 of the decimation ratio (R=16); ORDER, default 3, CIC order N.
REQ-002 Port clk, input, 1, bus clock; the block has one clock.
REQ-003 Port reset_n, input, 1, reset, asynchronous and active-low.
REQ-004 Port clk7_en, input, 1, bitstream sample enable; all bitstream processing is qualified by it.
REQ-005 Port enable, input, 1, decoder run; low is a synchronous clear.
REQ-006 Port left, input, 1, left sigma-delta bitstream; 1 means +1 and 0 means -1.
REQ-007 Port right, input, 1, right sigma-delta bitstream with the same encoding.
REQ-008 Port ldata, output, DW, left PCM sample, two's complement.
REQ-009 Port rdata, output, DW, right PCM sample, two's complement.
REQ-010 Port sample_valid, output, 1, one-clk strobe marking new ldata/rdata.

Function
REQ-011 Each channel SHALL be an N=3, R=16, M=1 CIC decimator: three integrators at the clk7_en rate, then three combs at the decimated rate.
REQ-012 The input SHALL map to a 2-bit signed value of +1 or -1; integrator and comb registers SHALL be 14 bits wide (2 + N*DEC_LOG2) with modulo (wrap-around) arithmetic; integrator wrap is legal and SHALL NOT saturate.
REQ-013 A 4-bit phase counter SHALL increment on every clk cycle with clk7_en=1 and wrap from 15 to 0.
REQ-014 On a clk7_en cycle with phase==15, the comb chain SHALL take the post-update integrator-3 value, and comb delay registers SHALL update on that cycle only.
REQ-015 On the clk cycle after the comb update (not gated by clk7_en), ldata/rdata SHALL load sat15(comb3 << 2), and sample_valid SHALL be 1 for exactly that one clk cycle.
REQ-016 sat15 SHALL clamp to the range -16384 to +16383; comb output +4096 SHALL give 0x3FFF and -4096 SHALL give 0x4000.
REQ-017 Latency: one output per 16 clk7_en pulses; outputs reach steady state from the 3rd sample_valid after clear.
REQ-018 Both channels SHALL share the phase counter and strobe and update simultaneously.
REQ-019 When clk7_en=0, no state SHALL change except the output register and sample_valid pipeline stage.
REQ-020 When enable=0, the phase counter, integrators, combs, ldata and rdata SHALL clear to 0 and sample_valid SHALL be 0; the first strobe after enable rises SHALL follow the 16th clk7_en.
REQ-021 If enable falls in the same cycle as a pending strobe, the clear SHALL win and no strobe SHALL be emitted.
REQ-022 ldata and rdata SHALL hold their values between strobes.

Reset
REQ-023 reset_n low SHALL asynchronously clear all registers: phase=0, integrators and combs=0, ldata=0, rdata=0, sample_valid=0.
REQ-024 Deassertion of reset_n SHALL be consumed synchronously to clk.
REQ-025 Reset asserted mid-frame SHALL abort the frame without emitting a strobe.

Structure
REQ-026 A shared package SHALL hold DW, DEC_LOG2, ORDER, the derived CIC width (14) and the saturation limits +16383/-16384.
REQ-027 The block SHALL use one sub-module, paula_audio_cic_decim (single channel: integrators, combs, saturation), instantiated twice.
REQ-028 The phase counter and sample_valid generation SHALL live in the top level.

Verification
REQ-029 Constant left=1, right=0 with continuous clk7_en -> from the 3rd strobe, ldata=0x3FFF and rdata=0x4000.
REQ-030 Alternating 1,0 bitstream on both channels -> from the 3rd strobe, ldata=rdata=0.
REQ-031 Repeating pattern 1,1,1,0 (mean +0.5) -> from the 3rd strobe, output=+8192 (0x2000).
REQ-032 clk7_en asserted once every 4 clk -> sample_valid period is 64 clk, each pulse 1 clk wide, and values match REQ-029.
REQ-033 reset_n pulsed low mid-frame (phase=7) -> outputs clear immediately with no strobe, and the next strobe follows 16 clk7_en after release.
REQ-034 Run constant +1 for 1000 clk7_en with integrator wrap, then switch to constant -1 -> output is 0x4000 from the 3rd strobe after the switch, with no glitch caused by the wrap.
